// File: rtl/onchip_mem_arbiter.sv
// onchip_mem_arbiter: shares the single port of the 8K x 256 frame memory between
// port 0 (read/write) and port 1 (read only); one accept per cycle, command registered
// 1 cycle after accept, read valid 1+RD_LATENCY after accept. Build option ONCHIP_ARB_RR_EN
// selects round-robin arbitration; default is fixed priority with HOLD_MAX starvation relief.
module onchip_mem_arbiter #(
  parameter int RD_LATENCY = 2,
  parameter int HOLD_MAX   = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         p0_read,
  input  logic         p0_write,
  input  logic [12:0]  p0_addr,
  input  logic [255:0] p0_write_data,
  input  logic [31:0]  p0_byte_enable,
  output logic         p0_waitrequest,
  output logic [255:0] p0_read_data,
  output logic         p0_read_data_valid,
  input  logic         p1_read,
  input  logic [12:0]  p1_addr,
  output logic         p1_waitrequest,
  output logic [255:0] p1_read_data,
  output logic         p1_read_data_valid,
  output logic         onchip_mem_chip_select,
  output logic         onchip_mem_clk_ena,
  output logic [12:0]  onchip_mem_addr,
  output logic [31:0]  onchip_mem_byte_enable,
  output logic [255:0] onchip_mem_write_data,
  output logic         onchip_mem_write,
  input  logic [255:0] onchip_mem_read_data,
  output logic         proto_err
);

  logic p0_req, p1_req, pick_p1, grant0, grant1;

  // registered memory command; own = requester of the command (1 = port 1)
  logic         cs_q, cs_d, wr_q, wr_d, own_q, own_d, proto_q, proto_d;
  logic [12:0]  addr_q, addr_d;
  logic [31:0]  be_q, be_d;
  logic [255:0] wd_q, wd_d;

  // read tags travel alongside the memory latency so data can be steered to its owner
  logic [RD_LATENCY-1:0] tag_vld_q, tag_vld_d, tag_own_q, tag_own_d;

  assign p0_req = p0_read | p0_write;
  assign p1_req = p1_read;

`ifdef ONCHIP_ARB_RR_EN
  logic last_q, last_d;

  // under contention the port that was not granted last wins
  always_comb begin
    pick_p1 = p1_req && (!p0_req || !last_q);
    last_d  = last_q;
    if (grant0)      last_d = 1'b0;
    else if (grant1) last_d = 1'b1;
  end
`else
  localparam int HW = $clog2(HOLD_MAX + 1);
  logic [HW-1:0] hold_q, hold_d;

  // port 0 has priority until port 1 has been passed over HOLD_MAX times in a row
  always_comb begin
    pick_p1 = p1_req && (!p0_req || (hold_q == HW'(HOLD_MAX)));
    hold_d  = hold_q;
    if (!p1_req || grant1)                        hold_d = '0;
    else if (grant0 && (hold_q != HW'(HOLD_MAX))) hold_d = hold_q + 1'b1;
  end
`endif

  assign grant1         = rst_n && pick_p1;
  assign grant0         = rst_n && p0_req && !pick_p1;
  assign p0_waitrequest = !rst_n || (p0_req && pick_p1);
  assign p1_waitrequest = !rst_n || (p1_req && !pick_p1);

  // build the next memory command from the winning port; idle keeps addr/data
  always_comb begin
    cs_d    = 1'b0;
    wr_d    = 1'b0;
    own_d   = 1'b0;
    addr_d  = addr_q;
    be_d    = be_q;
    wd_d    = wd_q;
    proto_d = proto_q | (p0_read & p0_write);
    if (grant0) begin
      // a simultaneous read+write is treated as a write; the read is dropped
      cs_d   = 1'b1;
      wr_d   = p0_write;
      addr_d = p0_addr;
      be_d   = p0_write ? p0_byte_enable : '1;
      if (p0_write) wd_d = p0_write_data;
    end else if (grant1) begin
      cs_d   = 1'b1;
      own_d  = 1'b1;
      addr_d = p1_addr;
      be_d   = '1;
    end
  end

  // shift issued-read tags; stage 0 captures the command currently on the memory port
  always_comb begin
    tag_vld_d    = tag_vld_q;
    tag_own_d    = tag_own_q;
    tag_vld_d[0] = cs_q & ~wr_q;
    tag_own_d[0] = own_q;
    for (int i = 1; i < RD_LATENCY; i++) begin
      tag_vld_d[i] = tag_vld_q[i-1];
      tag_own_d[i] = tag_own_q[i-1];
    end
  end

  // state update with synchronous reset; reset also flushes in-flight read tags
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cs_q      <= 1'b0;
      wr_q      <= 1'b0;
      own_q     <= 1'b0;
      addr_q    <= '0;
      be_q      <= '0;
      wd_q      <= '0;
      proto_q   <= 1'b0;
      tag_vld_q <= '0;
      tag_own_q <= '0;
`ifdef ONCHIP_ARB_RR_EN
      last_q    <= 1'b0;
`else
      hold_q    <= '0;
`endif
    end else begin
      cs_q      <= cs_d;
      wr_q      <= wr_d;
      own_q     <= own_d;
      addr_q    <= addr_d;
      be_q      <= be_d;
      wd_q      <= wd_d;
      proto_q   <= proto_d;
      tag_vld_q <= tag_vld_d;
      tag_own_q <= tag_own_d;
`ifdef ONCHIP_ARB_RR_EN
      last_q    <= last_d;
`else
      hold_q    <= hold_d;
`endif
    end
  end

  assign onchip_mem_chip_select = cs_q;
  assign onchip_mem_clk_ena     = 1'b1;
  assign onchip_mem_addr        = addr_q;
  assign onchip_mem_byte_enable = be_q;
  assign onchip_mem_write_data  = wd_q;
  assign onchip_mem_write       = wr_q;
  assign proto_err              = proto_q;

  // read data is shared and unregistered; only the valid identifies the owner
  assign p0_read_data       = onchip_mem_read_data;
  assign p1_read_data       = onchip_mem_read_data;
  assign p0_read_data_valid = tag_vld_q[RD_LATENCY-1] & ~tag_own_q[RD_LATENCY-1];
  assign p1_read_data_valid = tag_vld_q[RD_LATENCY-1] &  tag_own_q[RD_LATENCY-1];

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// Bench for onchip_mem_arbiter: behavioural memory + transaction-level reference model.
module tb_onchip_mem_arbiter;
  localparam int RDL  = 2;
  localparam int HOLD = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         p0_read, p0_write, p1_read;
  logic [12:0]  p0_addr, p1_addr;
  logic [255:0] p0_write_data;
  logic [31:0]  p0_byte_enable;
  logic         p0_waitrequest, p1_waitrequest;
  logic [255:0] p0_read_data, p1_read_data;
  logic         p0_read_data_valid, p1_read_data_valid;
  logic         onchip_mem_chip_select, onchip_mem_clk_ena, onchip_mem_write;
  logic [12:0]  onchip_mem_addr;
  logic [31:0]  onchip_mem_byte_enable;
  logic [255:0] onchip_mem_write_data, onchip_mem_read_data;
  logic         proto_err;

  always #5 clk = ~clk;

  onchip_mem_arbiter #(.RD_LATENCY(RDL), .HOLD_MAX(HOLD)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_read(p0_read), .p0_write(p0_write), .p0_addr(p0_addr),
    .p0_write_data(p0_write_data), .p0_byte_enable(p0_byte_enable),
    .p0_waitrequest(p0_waitrequest), .p0_read_data(p0_read_data),
    .p0_read_data_valid(p0_read_data_valid),
    .p1_read(p1_read), .p1_addr(p1_addr), .p1_waitrequest(p1_waitrequest),
    .p1_read_data(p1_read_data), .p1_read_data_valid(p1_read_data_valid),
    .onchip_mem_chip_select(onchip_mem_chip_select), .onchip_mem_clk_ena(onchip_mem_clk_ena),
    .onchip_mem_addr(onchip_mem_addr), .onchip_mem_byte_enable(onchip_mem_byte_enable),
    .onchip_mem_write_data(onchip_mem_write_data), .onchip_mem_write(onchip_mem_write),
    .onchip_mem_read_data(onchip_mem_read_data), .proto_err(proto_err)
  );

  function automatic logic [255:0] init_word(input logic [12:0] a);
    return {8{ {19'h0, a} ^ 32'hA5A5A5A5 }};
  endfunction

  function automatic logic [255:0] merge(input logic [255:0] old, input logic [255:0] nw,
                                         input logic [31:0] be);
    logic [255:0] r;
    r = old;
    for (int i = 0; i < 32; i++) if (be[i]) r[8*i +: 8] = nw[8*i +: 8];
    return r;
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom();
    return r;
  endfunction

  // behavioural SRAM: command sampled at the clock edge, data out RDL cycles later
  bit           sram_wr [8192];
  logic [255:0] sram    [8192];
  logic [255:0] rd_pipe [RDL];
  assign onchip_mem_read_data = rd_pipe[RDL-1];

  always @(posedge clk) begin
    if (onchip_mem_chip_select && onchip_mem_write) begin
      sram[onchip_mem_addr]    <= merge(sram_wr[onchip_mem_addr] ? sram[onchip_mem_addr]
                                        : init_word(onchip_mem_addr),
                                        onchip_mem_write_data, onchip_mem_byte_enable);
      sram_wr[onchip_mem_addr] <= 1'b1;
    end
    rd_pipe[0] <= (onchip_mem_chip_select && !onchip_mem_write)
                  ? (sram_wr[onchip_mem_addr] ? sram[onchip_mem_addr] : init_word(onchip_mem_addr))
                  : '0;
    for (int i = 1; i < RDL; i++) rd_pipe[i] <= rd_pipe[i-1];
  end

  // reference model state
  bit           ref_wr  [8192];
  logic [255:0] ref_mem [8192];
  bit [1:0]     exp_ret [int];   // bit0: port-0 valid due, bit1: port-1 valid due
  logic [255:0] exp_dat [int];
  int           cyc, skip_n, total, bad;
  bit           prev_p1, m_proto, acc0, acc1;
  bit           e_cs, e_wr, e_fresh;
  logic [12:0]  e_addr;
  logic [31:0]  e_be;
  logic [255:0] e_wd;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [255:0] ref_rd(input logic [12:0] a);
    return ref_wr[a] ? ref_mem[a] : init_word(a);
  endfunction

  // one clock of checking and model update; inputs are already driven
  task automatic tick();
    bit p0q, p1q, win0, win1;
    bit [1:0] due;
    #1;
    p0q = p0_read | p0_write;
    p1q = p1_read;
    due = exp_ret.exists(cyc) ? exp_ret[cyc] : 2'b00;
    chk("cs", onchip_mem_chip_select, e_cs);
    chk("wr", onchip_mem_write, e_wr);
    chk("addr", onchip_mem_addr, e_addr);
    chk("clk_ena", onchip_mem_clk_ena, 1'b1);
    if (e_cs || e_fresh) chk("be", onchip_mem_byte_enable, e_be);
    if (e_wr || e_fresh) chk("wdata", onchip_mem_write_data, e_wd);
    chk("v0", p0_read_data_valid, due[0]);
    chk("v1", p1_read_data_valid, due[1]);
    if (due[0]) chk("d0", p0_read_data, exp_dat[cyc]);
    if (due[1]) chk("d1", p1_read_data, exp_dat[cyc]);
    chk("proto", proto_err, m_proto);
    if (exp_ret.exists(cyc)) begin exp_ret.delete(cyc); exp_dat.delete(cyc); end
    acc0 = 1'b0;
    acc1 = 1'b0;
    if (!rst_n) begin
      chk("p0_wait_rst", p0_waitrequest, 1'b1);
      chk("p1_wait_rst", p1_waitrequest, 1'b1);
      exp_ret.delete();
      exp_dat.delete();
      e_cs = 0; e_wr = 0; e_addr = '0; e_be = '0; e_wd = '0; e_fresh = 1;
      skip_n = 0; prev_p1 = 0; m_proto = 0;
    end else begin
`ifdef ONCHIP_ARB_RR_EN
      win1 = p1q && (!p0q || !prev_p1);
`else
      win1 = p1q && (!p0q || skip_n == HOLD);
`endif
      win0 = p0q && !win1;
      if (p0q) chk("p0_wait", p0_waitrequest, !win0);
      if (p1q) chk("p1_wait", p1_waitrequest, !win1);
      if (p0_read && p0_write) m_proto = 1;
      if (!p1q || win1) skip_n = 0;
      else if (win0 && skip_n < HOLD) skip_n++;
      e_cs = win0 || win1;
      e_wr = win0 && p0_write;
      if (win0 || win1) begin
        e_fresh = 0;
        prev_p1 = win1;
      end
      if (win0) begin
        e_addr = p0_addr;
        if (p0_write) begin
          e_be = p0_byte_enable;
          e_wd = p0_write_data;
          ref_mem[p0_addr] = merge(ref_rd(p0_addr), p0_write_data, p0_byte_enable);
          ref_wr[p0_addr]  = 1;
        end else begin
          e_be = '1;
          exp_ret[cyc + 1 + RDL] = 2'b01;
          exp_dat[cyc + 1 + RDL] = ref_rd(p0_addr);
        end
      end else if (win1) begin
        e_addr = p1_addr;
        e_be   = '1;
        exp_ret[cyc + 1 + RDL] = 2'b10;
        exp_dat[cyc + 1 + RDL] = ref_rd(p1_addr);
      end
      acc0 = win0;
      acc1 = win1;
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    p0_read = 0; p0_write = 0; p1_read = 0;
    repeat (n) tick();
  endtask

  initial begin
    int n1, p1_share_exp;
    bit p0_pend, p1_pend;
    int r;
    total = 0; bad = 0; cyc = 0;
    p0_read = 0; p0_write = 0; p0_addr = '0; p0_write_data = '0; p0_byte_enable = '0;
    p1_read = 0; p1_addr = '0; rst_n = 0;
    e_cs = 0; e_wr = 0; e_addr = '0; e_be = '0; e_wd = '0; e_fresh = 1;
    skip_n = 0; prev_p1 = 0; m_proto = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    repeat (2) tick();
    rst_n = 1;
    idle(2);

    // lone port-1 read of 0x0010
    p1_read = 1; p1_addr = 13'h0010;
    tick();
    idle(6);

    // partial write to the top word, then read it back
    p0_write = 1; p0_addr = 13'h1FFF; p0_byte_enable = 32'h0000FFFF;
    p0_write_data = rand256();
    tick();
    p0_write = 0; p0_read = 1;
    tick();
    idle(6);

    // both ports reading continuously for 34 cycles
    n1 = 0;
    p0_read = 1; p0_addr = 13'($urandom_range(0, 63));
    p1_read = 1; p1_addr = 13'($urandom_range(0, 63));
    for (int k = 0; k < 34; k++) begin
      tick();
      if (acc1) n1++;
      if (acc0) p0_addr = 13'($urandom_range(0, 63));
      if (acc1) p1_addr = 13'($urandom_range(0, 63));
    end
`ifdef ONCHIP_ARB_RR_EN
    p1_share_exp = 17;
`else
    p1_share_exp = 2;
`endif
    chk("p1_share", 256'(n1), 256'(p1_share_exp));
    idle(6);

    // read and write together on port 0
    p0_read = 1; p0_write = 1; p0_addr = 13'h0021; p0_byte_enable = 32'hFFFF0000;
    p0_write_data = rand256();
    tick();
    idle(8);

    // random mixed traffic, requests held until accepted
    p0_pend = 0; p1_pend = 0;
    for (int k = 0; k < 400; k++) begin
      if (!p0_pend) begin
        r = $urandom_range(0, 3);
        p0_read = (r == 1); p0_write = (r == 2);
        p0_addr = 13'($urandom_range(0, 31));
        p0_write_data = rand256();
        p0_byte_enable = $urandom();
      end
      if (!p1_pend) begin
        p1_read = 1'($urandom_range(0, 1));
        p1_addr = 13'($urandom_range(0, 31));
      end
      tick();
      p0_pend = (p0_read || p0_write) && !acc0;
      p1_pend = p1_read && !acc1;
    end
    idle(6);

    // one-cycle reset while two reads are in flight
    p0_read = 1; p0_addr = 13'h0005;
    tick();
    p0_addr = 13'h0006;
    tick();
    p0_read = 0;
    rst_n = 0;
    tick();
    rst_n = 1;
    idle(8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // hard stop in case the stimulus ever stalls
  initial begin
    #200000;
    $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
